// File: rtl/snake_pkg.sv
// Shared constants for the snake game: heading encodings, key bit indices and debounce length.
package snake_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  localparam int unsigned KEY_RIGHT = 0;
  localparam int unsigned KEY_LEFT  = 1;
  localparam int unsigned KEY_DOWN  = 2;
  localparam int unsigned KEY_UP    = 3;

  // 20 ms at 50 MHz
  localparam int unsigned DEBOUNCE_20MS = 1_000_000;

  // Opposite heading differs only in the low bit (UP<->DOWN, LEFT<->RIGHT).
  function automatic logic [1:0] dir_reverse(input logic [1:0] d);
    return {d[1], ~d[0]};
  endfunction

endpackage

// File: rtl/key_debounce_cell.sv
// One key: 2-flop synchroniser, stable-run debouncer and registered press-edge pulse.
module key_debounce_cell
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned CNT_W           = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic key_raw_n,
  output logic key_db_n,
  output logic key_press
);

  typedef enum logic {StStable, StCounting} db_state_e;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(DEBOUNCE_CYCLES - 1);

  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       sync_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             flip;
  logic             s;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], key_raw_n};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StStable;
      cnt_q   <= '0;
      level_q <= 1'b1;
      press_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      press_q <= press_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flip    = 1'b0;
    unique case (state_q)
      StStable: begin
        cnt_d = '0;
        if (s != level_q) begin
          state_d = StCounting;
          cnt_d   = CNT_W'(1);
        end
      end
      StCounting: begin
        if (s == level_q) begin
          state_d = StStable;
          cnt_d   = '0;
        end else if (cnt_q == LastCnt) begin
          state_d = StStable;
          cnt_d   = '0;
          flip    = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = StStable;
        cnt_d   = '0;
      end
    endcase
  end

  // Press pulse is registered alongside the level so it aligns with the first low cycle.
  always_comb begin
    level_d = level_q ^ flip;
    press_d = flip & level_q;
  end

  assign key_db_n  = level_q;
  assign key_press = press_q;

endmodule

// File: rtl/key_input_unit.sv
// Four debounced push buttons plus the snake heading register with reversal rejection.
module key_input_unit
  import snake_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_20MS,
  parameter int unsigned CNT_W           = 24
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_raw_n,
  input  logic       dir_clear,
  output logic [3:0] key_db_n,
  output logic [3:0] key_press,
  output logic [1:0] dir,
  output logic       dir_changed
);

  logic [1:0] dir_q, dir_d;
  logic       chg_q, chg_d;
  logic [1:0] cand;

  for (genvar i = 0; i < 4; i++) begin : g_key
    key_debounce_cell #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .key_raw_n(key_raw_n[i]),
      .key_db_n (key_db_n[i]),
      .key_press(key_press[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_q <= DIR_RIGHT;
      chg_q <= 1'b0;
    end else begin
      dir_q <= dir_d;
      chg_q <= chg_d;
    end
  end

  // Only the top-priority press is considered; a reversal is dropped without fallback.
  always_comb begin
    cand = DIR_RIGHT;
    if (key_press[KEY_UP]) begin
      cand = DIR_UP;
    end else if (key_press[KEY_DOWN]) begin
      cand = DIR_DOWN;
    end else if (key_press[KEY_LEFT]) begin
      cand = DIR_LEFT;
    end
    dir_d = dir_q;
    if (dir_clear) begin
      dir_d = DIR_RIGHT;
    end else if ((|key_press) && (cand != dir_reverse(dir_q))) begin
      dir_d = cand;
    end
    chg_d = (dir_d != dir_q);
  end

  assign dir         = dir_q;
  assign dir_changed = chg_q;

endmodule

// File: tb/tb_key_input_unit.sv
// Directed and random stimulus for key_input_unit against a cycle-level behavioural model.
module tb_key_input_unit;

  localparam int unsigned DC = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_raw_n = 4'hF;
  logic       dir_clear = 1'b0;
  logic [3:0] key_db_n;
  logic [3:0] key_press;
  logic [1:0] dir;
  logic       dir_changed;

  int checks = 0;
  int failures = 0;

  // Behavioural model state
  logic [3:0] m_s1, m_s2, m_lvl, m_press;
  logic [1:0] m_dir;
  logic       m_chg;
  int         m_run[4];

  logic [3:0] seen_press;
  logic       seen_chg;

  key_input_unit #(
    .DEBOUNCE_CYCLES(DC),
    .CNT_W          (5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_raw_n  (key_raw_n),
    .dir_clear  (dir_clear),
    .key_db_n   (key_db_n),
    .key_press  (key_press),
    .dir        (dir),
    .dir_changed(dir_changed)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a == 2'd0 && b == 2'd1) || (a == 2'd1 && b == 2'd0) ||
           (a == 2'd2 && b == 2'd3) || (a == 2'd3 && b == 2'd2);
  endfunction

  task automatic model_update();
    logic [3:0] new_lvl;
    logic [1:0] nd, cand;
    if (rst) begin
      m_s1 = 4'hF; m_s2 = 4'hF; m_lvl = 4'hF; m_press = 4'h0;
      m_dir = 2'd3; m_chg = 1'b0;
      for (int i = 0; i < 4; i++) m_run[i] = 0;
    end else begin
      nd = m_dir;
      if (dir_clear) begin
        nd = 2'd3;
      end else if (m_press != 4'h0) begin
        if (m_press[3]) cand = 2'd0;
        else if (m_press[2]) cand = 2'd1;
        else if (m_press[1]) cand = 2'd2;
        else cand = 2'd3;
        if (!is_reverse(cand, m_dir)) nd = cand;
      end
      m_chg = (nd != m_dir);
      m_dir = nd;
      new_lvl = m_lvl;
      for (int i = 0; i < 4; i++) begin
        if (m_s2[i] != m_lvl[i]) begin
          m_run[i]++;
          if (m_run[i] == int'(DC)) begin
            new_lvl[i] = ~m_lvl[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_press = m_lvl & ~new_lvl;
      m_lvl = new_lvl;
      m_s2 = m_s1;
      m_s1 = key_raw_n;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    seen_press |= key_press;
    seen_chg   |= dir_changed;
    chk("model_key_db_n", key_db_n, m_lvl);
    chk("model_key_press", key_press, m_press);
    chk("model_dir", {2'b00, dir}, {2'b00, m_dir});
    chk("model_dir_changed", {3'b000, dir_changed}, {3'b000, m_chg});
  endtask

  task automatic press_release(input logic [3:0] pat);
    key_raw_n = pat;
    repeat (20) step();
    key_raw_n = 4'hF;
    repeat (20) step();
  endtask

  initial begin
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
    chk("reset_key_db_n", key_db_n, 4'hF);
    chk("reset_key_press", key_press, 4'h0);
    chk("reset_dir", {2'b00, dir}, 4'h3);
    chk("reset_dir_changed", {3'b000, dir_changed}, 4'h0);

    // Up press: level must flip exactly 18 cycles after the raw edge
    key_raw_n = 4'b0111;
    repeat (17) step();
    chk("up_before_latency", key_db_n, 4'hF);
    step();
    chk("up_at_latency", key_db_n, 4'b0111);
    chk("up_press_pulse", key_press, 4'b1000);
    step();
    chk("up_press_one_cycle", key_press, 4'h0);
    chk("up_dir", {2'b00, dir}, 4'h0);
    chk("up_dir_changed", {3'b000, dir_changed}, 4'h1);
    key_raw_n = 4'hF;
    repeat (20) step();

    // Glitches of 5 and 15 cycles are rejected
    seen_press = 4'h0;
    key_raw_n = 4'b1101;
    repeat (5) step();
    key_raw_n = 4'hF;
    repeat (5) step();
    key_raw_n = 4'b1101;
    repeat (15) step();
    key_raw_n = 4'hF;
    repeat (20) step();
    chk("glitch_no_press", seen_press, 4'h0);
    chk("glitch_key_db_n", key_db_n, 4'hF);

    // Clear back to RIGHT, then left is a reversal
    dir_clear = 1'b1;
    step();
    dir_clear = 1'b0;
    chk("clear_dir", {2'b00, dir}, 4'h3);
    chk("clear_changed", {3'b000, dir_changed}, 4'h1);
    step();
    seen_chg = 1'b0;
    press_release(4'b1101);
    chk("reverse_dir", {2'b00, dir}, 4'h3);
    chk("reverse_no_change", {3'b000, seen_chg}, 4'h0);
    press_release(4'b1011);
    chk("down_dir", {2'b00, dir}, 4'h1);

    // DOWN -> LEFT -> UP, then up+down together keeps UP with no fallback
    press_release(4'b1101);
    chk("left_dir", {2'b00, dir}, 4'h2);
    press_release(4'b0111);
    chk("up2_dir", {2'b00, dir}, 4'h0);
    seen_chg = 1'b0;
    press_release(4'b0011);
    chk("updown_dir", {2'b00, dir}, 4'h0);
    chk("updown_no_change", {3'b000, seen_chg}, 4'h0);
    press_release(4'b1101);
    chk("left2_dir", {2'b00, dir}, 4'h2);
    press_release(4'b0101);
    chk("upleft_dir", {2'b00, dir}, 4'h0);

    // dir_clear coincident with a left press from DOWN
    press_release(4'b1101);
    press_release(4'b1011);
    chk("down2_dir", {2'b00, dir}, 4'h1);
    key_raw_n = 4'b1101;
    repeat (18) step();
    chk("clrpress_pulse", key_press, 4'b0010);
    dir_clear = 1'b1;
    step();
    dir_clear = 1'b0;
    chk("clrpress_dir", {2'b00, dir}, 4'h3);
    chk("clrpress_changed", {3'b000, dir_changed}, 4'h1);
    step();
    chk("clrpress_changed_once", {3'b000, dir_changed}, 4'h0);
    key_raw_n = 4'hF;
    repeat (20) step();

    // Reset at count 10 discards the in-progress debounce
    key_raw_n = 4'b0111;
    repeat (12) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (6) step();
    chk("rst_midcount_key_db_n", key_db_n, 4'hF);
    key_raw_n = 4'hF;
    repeat (20) step();

    // Random phase
    for (int n = 0; n < 300; n++) begin
      key_raw_n = 4'($urandom);
      dir_clear = ($urandom_range(0, 7) == 0);
      rst = ($urandom_range(0, 39) == 0);
      step();
      dir_clear = 1'b0;
      rst = 1'b0;
      repeat ($urandom_range(0, 24)) step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
